// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches 32-bit words over req/ack, presents DD/AA/BA/FS fields,
// strobes dp_we for ALU ops and resolves branch/jump/halt. Optional single-step mode: STEP_EN.
module instr_sequencer #(
    parameter int PC_W = 10
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            run,
`ifdef STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic [3:0]      Status,
    output logic            dp_we,
    output logic [4:0]      DDL,
    output logic [4:0]      AAL,
    output logic [4:0]      BBL,
    output logic [4:0]      FSL,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

`ifdef STEP_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3
    } state_t;
`endif

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_req;
    logic            r_dp_we;
    logic            r_halted;

    logic [1:0]      w_cls;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_jmp_tgt;
    logic            w_cond;

    // Next-pc candidates; all arithmetic wraps naturally at PC_W bits
    assign w_cls     = r_ir[11:10];
    assign w_pc_inc  = r_pc + PC_W'(1'b1);
    assign w_br_tgt  = w_pc_inc + PC_W'($signed(r_ir[9:0]));
    assign w_jmp_tgt = PC_W'(r_ir[9:0]);
    assign w_cond    = Status[r_ir[13:12]];

    // Fields come straight from IR, which only changes on the fetch that starts EXEC
    assign FSL       = r_ir[31:27];
    assign DDL       = r_ir[26:22];
    assign AAL       = r_ir[21:17];
    assign BBL       = r_ir[16:12];
    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign dp_we     = r_dp_we;
    assign halted    = r_halted;

    // Sequencer FSM with registered handshake, strobe and halt outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_ir     <= 32'd0;
            r_req    <= 1'b0;
            r_dp_we  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_req   <= 1'b0;
                        r_dp_we <= (imem_data[11:10] == 2'b00);
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_dp_we <= 1'b0;
                    case (w_cls)
                        2'b00:   r_pc <= w_pc_inc;
                        2'b01:   r_pc <= w_cond ? w_br_tgt : w_pc_inc;
                        2'b10:   r_pc <= w_jmp_tgt;
                        default: r_pc <= r_pc;
                    endcase
                    if (w_cls == 2'b11) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
`ifdef STEP_EN
                        r_state <= ST_PAUSE;
`else
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
`endif
                    end
                end
`ifdef STEP_EN
                ST_PAUSE: begin
                    if (step) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end
`endif
                ST_HALT: begin
                    r_halted <= 1'b1;
                    r_req    <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_req    <= 1'b0;
                    r_dp_we  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
